// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if
//  AHB-Lite bus bundle between a word-transfer initiator and a slave port.
//  Parameters: AW address width, DW data width.
//  Signals:
//    hsel, hwrite             select / direction        (master -> slave)
//    htrans[1:0]              IDLE/NONSEQ/SEQ           (master -> slave)
//    hsize[2:0], hburst[2:0]  transfer size / burst     (master -> slave)
//    haddr[AW-1:0]            address phase address     (master -> slave)
//    hwdata[DW-1:0]           data phase write data     (master -> slave)
//    hrdata[DW-1:0]           data phase read data      (slave -> master)
//    hready                   slave ready               (slave -> master)
interface ahb_lite_master_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic          hsel;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;

  modport master (
    output hsel, hwrite, htrans, hsize, hburst, haddr, hwdata,
    input  hrdata, hready
  );

  modport slave (
    input  hsel, hwrite, htrans, hsize, hburst, haddr, hwdata,
    output hrdata, hready
  );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//  Command-driven AHB-Lite initiator. Turns a SINGLE or INCR4 word command into
//  pipelined address/data phases, honours slave wait states and returns read
//  beats plus a completion pulse.
//  Ports:
//    clk, reset_n        clock, synchronous active-low reset
//    cmd_valid/ready     command handshake; cmd_write, cmd_burst, cmd_addr fields
//    wdata_rd, wdata     combinational pull strobe and next write beat
//    rdata_valid, rdata  one pulse per completed read beat
//    done                one pulse when the whole command has completed
//    ahb                 AHB-Lite master side (ahb_lite_master_if.master)
module ahb_lite_master #(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic          cmd_burst,
  input  logic [AW-1:0] cmd_addr,
  output logic          wdata_rd,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  output logic [DW-1:0] rdata,
  output logic          done,
  ahb_lite_master_if.master ahb
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_BURST, ST_LAST} state_t;

  state_t        state_q, state_d;
  logic          hsel_q, hsel_d;
  logic          hwrite_q, hwrite_d;
  logic [1:0]    htrans_q, htrans_d;
  logic [2:0]    hburst_q, hburst_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          done_q, done_d;
  logic [2:0]    issued_q, issued_d;
  logic [2:0]    completed_q, completed_d;

  logic [2:0]    beats;
  logic          addr_go;
  logic          data_go;

  // Write data is pulled exactly when a write address phase is accepted, so
  // the registered hwdata lines up with the following data phase.
  assign wdata_rd = hwrite_q & htrans_q[1] & ahb.hready;

  // An address phase is in flight in ADDR/BURST, a data phase in BURST/LAST;
  // both only advance on a cycle where the slave signals ready.
  assign addr_go = ((state_q == ST_ADDR) || (state_q == ST_BURST)) && ahb.hready;
  assign data_go = ((state_q == ST_BURST) || (state_q == ST_LAST)) && ahb.hready;
  assign beats   = (hburst_q == HBURST_INCR4) ? 3'd4 : 3'd1;

  always_comb begin
    state_d       = state_q;
    hsel_d        = hsel_q;
    hwrite_d      = hwrite_q;
    htrans_d      = htrans_q;
    hburst_d      = hburst_q;
    haddr_d       = haddr_q;
    hwdata_d      = wdata_rd ? wdata : hwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    issued_d      = issued_q;
    completed_d   = completed_q;

    if ((state_q == ST_IDLE) && cmd_valid) begin
      state_d     = ST_ADDR;
      hsel_d      = 1'b1;
      hwrite_d    = cmd_write;
      htrans_d    = HTRANS_NONSEQ;
      hburst_d    = cmd_burst ? HBURST_INCR4 : HBURST_SINGLE;
      haddr_d     = cmd_addr & ~AW'(3);
      issued_d    = 3'd0;
      completed_d = 3'd0;
    end

    if (data_go) begin
      completed_d = completed_q + 3'd1;
      if (!hwrite_q) begin
        rdata_d       = ahb.hrdata;
        rdata_valid_d = 1'b1;
      end
    end

    // Incrementing address with plain modular wrap, no 16-byte boundary wrap.
    if (addr_go) begin
      issued_d = issued_q + 3'd1;
      if (issued_d == beats) begin
        state_d  = ST_LAST;
        htrans_d = HTRANS_IDLE;
        hsel_d   = 1'b0;
      end else begin
        state_d  = ST_BURST;
        htrans_d = HTRANS_SEQ;
        haddr_d  = haddr_q + AW'(4);
      end
    end

    if ((state_q == ST_LAST) && data_go && (completed_d == beats)) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      hsel_q        <= 1'b0;
      hwrite_q      <= 1'b0;
      htrans_q      <= HTRANS_IDLE;
      hburst_q      <= HBURST_SINGLE;
      haddr_q       <= '0;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      issued_q      <= 3'd0;
      completed_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      hsel_q        <= hsel_d;
      hwrite_q      <= hwrite_d;
      htrans_q      <= htrans_d;
      hburst_q      <= hburst_d;
      haddr_q       <= haddr_d;
      hwdata_q      <= hwdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign done        = done_q;

  assign ahb.hsel   = hsel_q;
  assign ahb.hwrite = hwrite_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hsize  = 3'b010;
  assign ahb.hburst = hburst_q;
  assign ahb.haddr  = haddr_q;
  assign ahb.hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master
//  Directed bench for ahb_lite_master. A small slave model returns
//  hrdata = {12'hC0D, data-phase address}; write beats come from wbuf.
module tb_ahb_lite_master;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_burst;
  logic [AW-1:0] cmd_addr;
  logic          wdata_rd;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          done;
  logic          hready_tb;
  logic [AW-1:0] dp_addr = '0;
  logic [5:0]    wptr = '0;
  logic [DW-1:0] wbuf [64];
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  ahb_lite_master_if #(.AW(AW), .DW(DW)) bus ();

  ahb_lite_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_burst(cmd_burst), .cmd_addr(cmd_addr),
    .wdata_rd(wdata_rd), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .ahb(bus)
  );

  // Slave model: remember the accepted address so the data phase returns a
  // value tied to it.
  assign bus.hready = hready_tb;
  assign bus.hrdata = {12'hC0D, dp_addr};
  always @(posedge clk) if (bus.hready && bus.htrans[1]) dp_addr <= bus.haddr;

  // Write beat source: advances whenever the DUT pulls a beat.
  assign wdata = wbuf[wptr];
  always @(posedge clk) if (wdata_rd) wptr <= wptr + 6'd1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic b, input logic [AW-1:0] a);
    cmd_valid = 1'b1; cmd_write = w; cmd_burst = b; cmd_addr = a;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(); tick();
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rst_cmd_ready: got %b want 1", cmd_ready); else passes++;
    checks++; if (bus.htrans !== 2'b00) $display("[TB] FAIL rst_htrans: got %b want 00", bus.htrans); else passes++;
    checks++; if (bus.hsel !== 1'b0) $display("[TB] FAIL rst_hsel: got %b want 0", bus.hsel); else passes++;
    checks++; if (bus.hwrite !== 1'b0) $display("[TB] FAIL rst_hwrite: got %b want 0", bus.hwrite); else passes++;
    checks++; if (bus.hburst !== 3'b000) $display("[TB] FAIL rst_hburst: got %b want 000", bus.hburst); else passes++;
    checks++; if (bus.hsize !== 3'b010) $display("[TB] FAIL rst_hsize: got %b want 010", bus.hsize); else passes++;
    checks++; if (bus.haddr !== 20'h0) $display("[TB] FAIL rst_haddr: got %h want 0", bus.haddr); else passes++;
    checks++; if (bus.hwdata !== 32'h0) $display("[TB] FAIL rst_hwdata: got %h want 0", bus.hwdata); else passes++;
    checks++; if (rdata_valid !== 1'b0) $display("[TB] FAIL rst_rdata_valid: got %b want 0", rdata_valid); else passes++;
    checks++; if (rdata !== 32'h0) $display("[TB] FAIL rst_rdata: got %h want 0", rdata); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_done: got %b want 0", done); else passes++;
    checks++; if (wdata_rd !== 1'b0) $display("[TB] FAIL rst_wdata_rd: got %b want 0", wdata_rd); else passes++;
    reset_n = 1'b1; tick();
  endtask

  task automatic test_single_write();
    wbuf[wptr] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 20'h00010); tick();
    checks++; if (bus.htrans !== 2'b10) $display("[TB] FAIL sw_htrans_c1: got %b want 10", bus.htrans); else passes++;
    checks++; if (bus.haddr !== 20'h00010) $display("[TB] FAIL sw_haddr_c1: got %h want 00010", bus.haddr); else passes++;
    checks++; if (bus.hsel !== 1'b1) $display("[TB] FAIL sw_hsel_c1: got %b want 1", bus.hsel); else passes++;
    checks++; if (bus.hwrite !== 1'b1) $display("[TB] FAIL sw_hwrite_c1: got %b want 1", bus.hwrite); else passes++;
    checks++; if (bus.hburst !== 3'b000) $display("[TB] FAIL sw_hburst_c1: got %b want 000", bus.hburst); else passes++;
    checks++; if (wdata_rd !== 1'b1) $display("[TB] FAIL sw_wdata_rd_c1: got %b want 1", wdata_rd); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL sw_cmd_ready_c1: got %b want 0", cmd_ready); else passes++;
    cmd_valid = 1'b0; tick();
    checks++; if (bus.hwdata !== 32'hDEADBEEF) $display("[TB] FAIL sw_hwdata_c2: got %h want deadbeef", bus.hwdata); else passes++;
    checks++; if (bus.htrans !== 2'b00) $display("[TB] FAIL sw_htrans_c2: got %b want 00", bus.htrans); else passes++;
    checks++; if (bus.hsel !== 1'b0) $display("[TB] FAIL sw_hsel_c2: got %b want 0", bus.hsel); else passes++;
    checks++; if (wdata_rd !== 1'b0) $display("[TB] FAIL sw_wdata_rd_c2: got %b want 0", wdata_rd); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL sw_done_c2: got %b want 0", done); else passes++;
    tick();
    checks++; if (done !== 1'b1) $display("[TB] FAIL sw_done_c3: got %b want 1", done); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL sw_cmd_ready_c3: got %b want 1", cmd_ready); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("[TB] FAIL sw_done_c4: got %b want 0", done); else passes++;
  endtask

  task automatic test_incr4_read();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    issue(1'b0, 1'b1, 20'h00100);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        cmd_valid = 1'b0;
        checks++; if (bus.hburst !== 3'b011) $display("[TB] FAIL r4_hburst: got %b want 011", bus.hburst); else passes++;
        checks++; if (wdata_rd !== 1'b0) $display("[TB] FAIL r4_wdata_rd: got %b want 0", wdata_rd); else passes++;
      end
      ea = 20'h00100 + 20'(4 * i);
      checks++; if (bus.htrans !== ((i == 0) ? 2'b10 : 2'b11)) $display("[TB] FAIL r4_htrans_%0d: got %b", i, bus.htrans); else passes++;
      checks++; if (bus.haddr !== ea) $display("[TB] FAIL r4_haddr_%0d: got %h want %h", i, bus.haddr, ea); else passes++;
      checks++; if (rdata_valid !== (i >= 2)) $display("[TB] FAIL r4_rvalid_c%0d: got %b want %b", i + 1, rdata_valid, (i >= 2)); else passes++;
      if (i >= 2) begin
        ed = 32'hC0D00100 + 32'(4 * (i - 2));
        checks++; if (rdata !== ed) $display("[TB] FAIL r4_rdata_c%0d: got %h want %h", i + 1, rdata, ed); else passes++;
      end
    end
    tick();
    checks++; if (bus.htrans !== 2'b00) $display("[TB] FAIL r4_htrans_c5: got %b want 00", bus.htrans); else passes++;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hC0D00108) $display("[TB] FAIL r4_beat2: got %b/%h want 1/c0d00108", rdata_valid, rdata); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL r4_done_c5: got %b want 0", done); else passes++;
    tick();
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hC0D0010C) $display("[TB] FAIL r4_beat3: got %b/%h want 1/c0d0010c", rdata_valid, rdata); else passes++;
    checks++; if (done !== 1'b1) $display("[TB] FAIL r4_done_c6: got %b want 1", done); else passes++;
    tick();
    checks++; if (rdata_valid !== 1'b0 || done !== 1'b0) $display("[TB] FAIL r4_c7_quiet: got %b/%b want 0/0", rdata_valid, done); else passes++;
  endtask

  task automatic test_wait_states();
    logic [5:0] b;
    b = wptr;
    wbuf[b] = 32'h11111111; wbuf[b + 6'd1] = 32'h22222222;
    wbuf[b + 6'd2] = 32'h33333333; wbuf[b + 6'd3] = 32'h44444444;
    issue(1'b1, 1'b1, 20'h00200); tick();
    cmd_valid = 1'b0;
    checks++; if (bus.htrans !== 2'b10 || bus.haddr !== 20'h00200) $display("[TB] FAIL ws_c1: got %b/%h want 10/00200", bus.htrans, bus.haddr); else passes++;
    tick();
    checks++; if (bus.htrans !== 2'b11 || bus.haddr !== 20'h00204) $display("[TB] FAIL ws_c2: got %b/%h want 11/00204", bus.htrans, bus.haddr); else passes++;
    checks++; if (bus.hwdata !== 32'h11111111) $display("[TB] FAIL ws_hwdata_c2: got %h want 11111111", bus.hwdata); else passes++;
    hready_tb = 1'b0; #1;
    checks++; if (wdata_rd !== 1'b0) $display("[TB] FAIL ws_wdata_rd_low: got %b want 0", wdata_rd); else passes++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.htrans !== 2'b11 || bus.haddr !== 20'h00204) $display("[TB] FAIL ws_frozen_addr_%0d: got %b/%h want 11/00204", k, bus.htrans, bus.haddr); else passes++;
      checks++; if (bus.hwdata !== 32'h11111111) $display("[TB] FAIL ws_frozen_hwdata_%0d: got %h want 11111111", k, bus.hwdata); else passes++;
      checks++; if (wdata_rd !== 1'b0 || done !== 1'b0) $display("[TB] FAIL ws_frozen_strobes_%0d: got %b/%b want 0/0", k, wdata_rd, done); else passes++;
    end
    hready_tb = 1'b1; #1;
    checks++; if (wdata_rd !== 1'b1) $display("[TB] FAIL ws_wdata_rd_resume: got %b want 1", wdata_rd); else passes++;
    tick();
    checks++; if (bus.haddr !== 20'h00208 || bus.hwdata !== 32'h22222222) $display("[TB] FAIL ws_c6: got %h/%h want 00208/22222222", bus.haddr, bus.hwdata); else passes++;
    tick();
    checks++; if (bus.haddr !== 20'h0020C || bus.hwdata !== 32'h33333333) $display("[TB] FAIL ws_c7: got %h/%h want 0020c/33333333", bus.haddr, bus.hwdata); else passes++;
    tick();
    checks++; if (bus.htrans !== 2'b00 || bus.hwdata !== 32'h44444444) $display("[TB] FAIL ws_c8: got %b/%h want 00/44444444", bus.htrans, bus.hwdata); else passes++;
    tick();
    checks++; if (done !== 1'b1) $display("[TB] FAIL ws_done: got %b want 1", done); else passes++;
    checks++; if (6'(wptr - b) !== 6'd4) $display("[TB] FAIL ws_beats_pulled: got %0d want 4", 6'(wptr - b)); else passes++;
    tick();
  endtask

  task automatic test_wrap_and_align();
    logic [AW-1:0] ea [4];
    ea[0] = 20'hFFFF8; ea[1] = 20'hFFFFC; ea[2] = 20'h00000; ea[3] = 20'h00004;
    issue(1'b0, 1'b1, 20'hFFFF8);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmd_valid = 1'b0;
      checks++; if (bus.haddr !== ea[i]) $display("[TB] FAIL wrap_haddr_%0d: got %h want %h", i, bus.haddr, ea[i]); else passes++;
    end
    tick();
    checks++; if (rdata !== 32'hC0D00000) $display("[TB] FAIL wrap_rdata_beat2: got %h want c0d00000", rdata); else passes++;
    tick();
    checks++; if (rdata !== 32'hC0D00004 || done !== 1'b1) $display("[TB] FAIL wrap_last: got %h/%b want c0d00004/1", rdata, done); else passes++;
    tick();
    issue(1'b0, 1'b0, 20'h00103); tick();
    cmd_valid = 1'b0;
    checks++; if (bus.haddr !== 20'h00100) $display("[TB] FAIL align_haddr: got %h want 00100", bus.haddr); else passes++;
    checks++; if (bus.hburst !== 3'b000 || bus.htrans !== 2'b10) $display("[TB] FAIL align_ctrl: got %b/%b want 000/10", bus.hburst, bus.htrans); else passes++;
    tick(); tick();
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hC0D00100) $display("[TB] FAIL align_rdata: got %b/%h want 1/c0d00100", rdata_valid, rdata); else passes++;
    checks++; if (done !== 1'b1) $display("[TB] FAIL align_done: got %b want 1", done); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] b;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    b = wptr;
    for (int k = 0; k < 4; k++) wbuf[b + 6'(k)] = 32'hA0000001 + 32'(k);
    wbuf[b + 6'd4] = 32'hB0000005;
    issue(1'b1, 1'b1, 20'h00300); tick();
    checks++; if (bus.haddr !== 20'h00300 || cmd_ready !== 1'b0) $display("[TB] FAIL b2b_c1: got %h/%b want 00300/0", bus.haddr, cmd_ready); else passes++;
    // Second command presented while busy; must only be taken in the done cycle.
    cmd_burst = 1'b0; cmd_addr = 20'h00400;
    for (int k = 0; k < 4; k++) begin
      tick();
      ed = 32'hA0000001 + 32'(k);
      checks++; if (bus.hwdata !== ed) $display("[TB] FAIL b2b_hwdata_%0d: got %h want %h", k, bus.hwdata, ed); else passes++;
      checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL b2b_busy_%0d: got %b want 0", k, cmd_ready); else passes++;
      if (k < 3) begin
        ea = 20'h00304 + 20'(4 * k);
        checks++; if (bus.haddr !== ea || bus.hburst !== 3'b011) $display("[TB] FAIL b2b_haddr_%0d: got %h/%b want %h/011", k, bus.haddr, bus.hburst, ea); else passes++;
      end
    end
    tick();
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) $display("[TB] FAIL b2b_done1: got %b/%b want 1/1", done, cmd_ready); else passes++;
    checks++; if (bus.htrans !== 2'b00) $display("[TB] FAIL b2b_idle_gap: got %b want 00", bus.htrans); else passes++;
    tick();
    cmd_valid = 1'b0;
    checks++; if (bus.htrans !== 2'b10 || bus.haddr !== 20'h00400) $display("[TB] FAIL b2b_cmd2_addr: got %b/%h want 10/00400", bus.htrans, bus.haddr); else passes++;
    checks++; if (bus.hburst !== 3'b000 || done !== 1'b0) $display("[TB] FAIL b2b_cmd2_ctrl: got %b/%b want 000/0", bus.hburst, done); else passes++;
    tick();
    checks++; if (bus.hwdata !== 32'hB0000005) $display("[TB] FAIL b2b_cmd2_hwdata: got %h want b0000005", bus.hwdata); else passes++;
    tick();
    checks++; if (done !== 1'b1) $display("[TB] FAIL b2b_done2: got %b want 1", done); else passes++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic saw;
    issue(1'b0, 1'b1, 20'h00500); tick();
    cmd_valid = 1'b0; tick(); tick();
    checks++; if (bus.haddr !== 20'h00508) $display("[TB] FAIL rmb_beat3_addr: got %h want 00508", bus.haddr); else passes++;
    reset_n = 1'b0; tick();
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("[TB] FAIL rmb_ready_done: got %b/%b want 1/0", cmd_ready, done); else passes++;
    checks++; if (bus.htrans !== 2'b00 || bus.hsel !== 1'b0 || bus.haddr !== 20'h0) $display("[TB] FAIL rmb_addr_phase: got %b/%b/%h want 00/0/0", bus.htrans, bus.hsel, bus.haddr); else passes++;
    checks++; if (bus.hburst !== 3'b000 || bus.hwrite !== 1'b0 || bus.hwdata !== 32'h0) $display("[TB] FAIL rmb_ctrl: got %b/%b/%h want 000/0/0", bus.hburst, bus.hwrite, bus.hwdata); else passes++;
    checks++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) $display("[TB] FAIL rmb_rdata: got %b/%h want 0/0", rdata_valid, rdata); else passes++;
    reset_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done !== 1'b0 || bus.htrans !== 2'b00) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) $display("[TB] FAIL rmb_abandoned: got activity %b want 0", saw); else passes++;
  endtask

  initial begin
    reset_n = 1'b0; hready_tb = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0; cmd_addr = '0;
    for (int i = 0; i < 64; i++) wbuf[i] = '0;
    tick();
    test_reset();
    test_single_write();
    test_incr4_read();
    test_wait_states();
    test_wrap_and_align();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
